data_mem_ctrl: RTL
==================

Name: data_mem_ctrl

Overview:
Data-memory stage directly downstream of the RV32I datapath. It accepts load/store requests (byte address, funct3 size, store data) over a valid/ready handshake and performs byte-lane stores into a 128-byte synchronous RAM. Loads return extracted and sign- or zero-extended data over a registered response channel. It replaces the zero-latency memory with a handshaked, byte-enable-correct, timing-clean memory.

Parameters:
ADDR_W, 7, byte-address width (128 bytes)
DEPTH_WORDS, 32, number of 32-bit RAM words (must equal 2**(ADDR_W-2))

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
req_valid  input  1  request present
req_ready  output  1  request accepted when req_valid & req_ready
req_we  input  1  1 = store, 0 = load
req_size  input  3  RV32I funct3 (LB/LH/LW/LBU/LHU or SB/SH/SW)
req_addr  input  ADDR_W  byte address
req_wdata  input  32  store data, right-aligned
rsp_valid  output  1  response present
rsp_ready  input  1  response consumed when rsp_valid & rsp_ready
rsp_rdata  output  32  load result, extended; 0 for stores
rsp_err  output  1  misaligned access (only with the optional feature)

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0. RAM contents are not reset. RAM writes are suppressed while rst=0.
- FSM states:
  - IDLE: req_ready=1. On a store accept, go to RESP. On a load accept, go to LOAD.
  - LOAD: the RAM word is available. Format it and register it into rsp_rdata. Go to RESP.
  - RESP: rsp_valid=1 and outputs are held stable. On rsp_ready=1, go to IDLE.
- req_ready=0 outside IDLE. Back-to-back accepts are not allowed: there is at least one IDLE cycle between requests.
- Store timing: accepted in cycle N, RAM written at the end of N, rsp_valid=1 from N+1 with rsp_rdata=0.
- Load timing: accepted in cycle N, RAM read at the end of N, rsp_valid=1 from N+2.
- Word index = addr[ADDR_W-1:2]. Byte lane = addr[1:0].
- Store byte enables:
  - SB: lane addr[1:0], with wdata[7:0] replicated into all lanes.
  - SH: lanes {addr[1],0} and {addr[1],1}, with wdata[15:0] replicated.
  - SW: all lanes.
  - funct3[1:0]=11 is treated as SW.
- Load extraction: take the byte or halfword at the lane offset, then extend.
  - LB and LH sign-extend from bit 7 or bit 15.
  - LBU and LHU zero-extend.
  - funct3 011, 110 and 111 are treated as LW.
- Load-after-store to the same word returns the newly written data, since the write completes before the next accept.
- Address wrap: none. The address space is exactly 2**ADDR_W bytes, and upper bits do not exist.
- Reset mid-operation returns to IDLE and discards any pending response. A store already committed at its accept edge remains in RAM.

Optional Feature:
DMEM_MISALIGN_ERR_EN
- Defined: misaligned accesses (SH/LH/LHU with addr[0]=1; SW/LW with addr[1:0]!=0) perform no RAM write. The response is rsp_err=1 and rsp_rdata=0 with normal latency.
- Undefined: rsp_err is tied to 0, misaligned low address bits are ignored (SH/LH use addr[1]; SW/LW use the word only), and the access completes normally.

Decomposition:
- Package dmem_pkg:
  - funct3 localparams LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010.
  - State enum typedef dmem_state_t {IDLE, LOAD, RESP}.
  - Byte-enable typedef logic [3:0] be_t.
- Sub-module dmem_ram: DEPTH_WORDS x 32 synchronous RAM with a 4-bit byte-enable write and a registered read. It has no reset and holds only the storage array.

Test Plan:
- Reset with rst=0 mid-RESP: rsp_valid=0 and req_ready=1 immediately (asynchronously); after release, IDLE behaviour.
- SW 0xDEADBEEF @0x10, then LW @0x10: store rsp_valid at N+1; load rsp_rdata=0xDEADBEEF at accept+2.
- SB 0x80 @0x13, then LB @0x13 and LBU @0x13: word 0x10 becomes 0x80ADBEEF; LB returns 0xFFFFFF80; LBU returns 0x00000080.
- SH 0x7B80 @0x16, then LH @0x16 and LHU @0x14: LH returns 0x00007B80; LHU returns the lower half, unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles after a load. rsp_valid and rsp_rdata must stay stable, req_ready=0, and further req_valid pulses are ignored.
- With DMEM_MISALIGN_ERR_EN, SW 0x12345678 @0x11: rsp_err=1, rsp_rdata=0, and word 0x10 is unchanged. Without the macro: word 0x10 becomes 0x12345678 and rsp_err=0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory stage.
// Optional macro: DMEM_MISALIGN_ERR_EN (misaligned accesses report rsp_err).
package dmem_pkg;

    // RV32I funct3 encodings for loads and stores
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {IDLE, LOAD, RESP} dmem_state_t;

    typedef logic [3:0] be_t;

    // Byte enables for a store; size 11 behaves as a word store
    function automatic be_t store_be(input logic [1:0] sz, input logic [1:0] lane);
        case (sz)
            2'b00:   return be_t'(4'b0001 << lane);
            2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate right-aligned store data across the lanes it may land in
    function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] wd);
        case (sz)
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    // Halfwords need addr[0]=0, words need addr[1:0]=0
    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lane);
        case (sz)
            2'b00:   return 1'b0;
            2'b01:   return lane[0];
            default: return |lane;
        endcase
    endfunction

    // Pick the addressed byte/halfword out of a RAM word and extend it
    function automatic logic [31:0] load_fmt(input logic [2:0] sz, input logic [1:0] lane,
                                             input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (sz)
            LB:      return {{24{b[7]}}, b};
            LH:      return {{16{h[15]}}, h};
            LBU:     return {24'd0, b};
            LHU:     return {16'd0, h};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-organised synchronous RAM with per-byte write enables and a
// registered read port. Storage only; contents are never reset.
module dmem_ram
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 32,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic             re,
    input  be_t              be,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // Byte-lane write and registered read at the same word index
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (re) rdata_q <= mem_q[idx];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// Handshaked data-memory stage: byte-lane stores into a 128-byte RAM,
// extended loads on a registered response channel.
// Optional macro: DMEM_MISALIGN_ERR_EN -- misaligned halfword/word accesses
// skip the RAM write and respond with rsp_err=1, rsp_rdata=0.
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int DEPTH_WORDS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    dmem_state_t state_q;
    logic [2:0]  size_q;
    logic [1:0]  lane_q;
    logic        mis_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        accept;
    logic        mis;
    logic        ram_we;
    logic        ram_re;
    logic [31:0] ram_rdata;

    assign accept = req_valid && (state_q == IDLE);

`ifdef DMEM_MISALIGN_ERR_EN
    assign mis = misaligned(req_size[1:0], req_addr[1:0]);
`else
    assign mis = 1'b0;
`endif

    // Writes are blocked while reset is held so a reset cannot corrupt RAM
    assign ram_we = accept && req_we && !mis && rst;
    assign ram_re = accept && !req_we;

    dmem_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (ADDR_W-2)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .re   (ram_re),
        .be   (store_be(req_size[1:0], req_addr[1:0])),
        .idx  (req_addr[ADDR_W-1:2]),
        .wdata(store_data(req_size[1:0], req_wdata)),
        .rdata(ram_rdata)
    );

    // Request/response sequencing with registered response outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            size_q  <= 3'd0;
            lane_q  <= 2'd0;
            mis_q   <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    size_q  <= req_size;
                    lane_q  <= req_addr[1:0];
                    mis_q   <= mis;
                    rdata_q <= 32'd0;
                    err_q   <= req_we ? mis : 1'b0;
                    state_q <= req_we ? RESP : LOAD;
                end
                LOAD: begin
                    rdata_q <= mis_q ? 32'd0 : load_fmt(size_q, lane_q, ram_rdata);
                    err_q   <= mis_q;
                    state_q <= RESP;
                end
                RESP: if (rsp_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule
